// File: rtl/alu_result_buffer_pkg.sv
// Shared types and helpers for the ALU result buffer: result entry layout and
// pointer sizing.
package alu_result_buffer_pkg;

  localparam int ALU_DATA_W = 12;

  typedef struct packed {
    logic                  ovf;
    logic [ALU_DATA_W-1:0] data;
  } result_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// First-word-fall-through buffer behind the 12-bit ALU, with occupancy,
// sticky overflow flag and saturating overflow/drop counters.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_overflow,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_ovf_sticky,
  output logic [CNT_W-1:0]         o_ovf_cnt,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

  // Each entry is {overflow, data}.
  logic [DATA_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            sticky;
  logic            empty, full, push, pop, drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_LVL);
  assign pop   = !empty && i_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push  = i_valid && (!full || pop);
  assign drop  = i_valid && full && !pop;

  // NOTE: the storage array has no reset; emptiness is tracked by count and
  // the output mux hides stale contents, so resetting it would buy nothing.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush) begin
      mem[wr_ptr] <= {i_overflow, i_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sticky <= 1'b0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW + 1)'(1);
      else if (pop && !push) count <= count - (PW + 1)'(1);
      if (push && i_overflow) sticky <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_flush),
    .inc   (push && i_overflow),
    .count (o_ovf_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_flush),
    .inc   (drop),
    .count (o_drop_cnt)
  );

  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    o_data     = '0;
    o_overflow = 1'b0;
    if (!empty) begin
      o_data     = mem[rd_ptr][DATA_W-1:0];
      o_overflow = mem[rd_ptr][DATA_W];
    end
  end

  assign o_valid      = !empty;
  assign o_count      = count;
  assign o_full       = full;
  assign o_ovf_sticky = sticky;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus a random
// phase, compared every cycle against a queue-based reference model.
module tb_alu_result_buffer;
  import alu_result_buffer_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 12;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_overflow;
  logic              i_flush;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_overflow;
  logic [$clog2(DEPTH):0] o_count;
  logic              o_full;
  logic              o_ovf_sticky;
  logic [CNT_W-1:0]  o_ovf_cnt;
  logic [CNT_W-1:0]  o_drop_cnt;

  alu_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_overflow   (i_overflow),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_overflow   (o_overflow),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_ovf_sticky (o_ovf_sticky),
    .o_ovf_cnt    (o_ovf_cnt),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a plain queue plus status values.
  result_t q[$];
  int      m_sticky;
  int      m_ovf_cnt;
  int      m_drop_cnt;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    q.delete();
    m_sticky   = 0;
    m_ovf_cnt  = 0;
    m_drop_cnt = 0;
  endtask

  // Apply one clock edge's worth of the buffer rules to the model.
  task automatic model_edge();
    result_t e;
    bit do_pop, accept;
    if (i_flush) begin
      model_clear();
      return;
    end
    do_pop = (q.size() > 0) && i_ready;
    accept = i_valid && ((q.size() < DEPTH) || do_pop);
    if (i_valid && !accept && (m_drop_cnt < CNT_MAX)) m_drop_cnt++;
    if (do_pop) void'(q.pop_front());
    if (accept) begin
      e.ovf  = i_overflow;
      e.data = i_data;
      q.push_back(e);
      if (i_overflow) begin
        m_sticky = 1;
        if (m_ovf_cnt < CNT_MAX) m_ovf_cnt++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(o_valid), 32'(q.size() > 0));
    check({tag, ".count"}, 32'(o_count), 32'(q.size()));
    check({tag, ".full"},  32'(o_full),  32'(q.size() == DEPTH));
    check({tag, ".data"},  32'(o_data),  (q.size() > 0) ? 32'(q[0].data) : 32'd0);
    check({tag, ".ovf"},   32'(o_overflow), (q.size() > 0) ? 32'(q[0].ovf) : 32'd0);
    check({tag, ".sticky"}, 32'(o_ovf_sticky), 32'(m_sticky));
    check({tag, ".ovf_cnt"}, 32'(o_ovf_cnt), 32'(m_ovf_cnt));
    check({tag, ".drop_cnt"}, 32'(o_drop_cnt), 32'(m_drop_cnt));
  endtask

  // Drive inputs, advance one edge in model and DUT, sample 1 ns after the edge.
  task automatic cycle(input string tag, input bit v, input logic [DATA_W-1:0] d,
                       input bit ovf, input bit rdy, input bit fl);
    i_valid    = v;
    i_data     = d;
    i_overflow = ovf;
    i_ready    = rdy;
    i_flush    = fl;
    model_edge();
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_flush();
    cycle("flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_overflow = 1'b0;
    i_flush = 1'b0; i_ready = 1'b0;
    model_clear();
    #12;
    check_all("reset");
    i_rst_n = 1'b1;

    // Reset asserted between edges must empty the buffer at once.
    cycle("rst_push0", 1'b1, 12'h123, 1'b1, 1'b0, 1'b0);
    cycle("rst_push1", 1'b1, 12'h456, 1'b0, 1'b0, 1'b0);
    cycle("rst_push2", 1'b1, 12'h789, 1'b1, 1'b0, 1'b0);
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    model_clear();
    check("midrst.valid", 32'(o_valid), 32'd0);
    check("midrst.count", 32'(o_count), 32'd0);
    check("midrst.ovf_cnt", 32'(o_ovf_cnt), 32'd0);
    check("midrst.sticky", 32'(o_ovf_sticky), 32'd0);
    #2;
    i_rst_n = 1'b1;
    cycle("post_rst", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Basic ordering with the consumer stalled.
    cycle("basic_p0", 1'b1, 12'h001, 1'b0, 1'b0, 1'b0);
    cycle("basic_p1", 1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0);
    cycle("basic_p2", 1'b1, 12'h800, 1'b0, 1'b0, 1'b0);
    check("basic.count3", 32'(o_count), 32'd3);
    check("basic.ovf_cnt1", 32'(o_ovf_cnt), 32'd1);
    check("basic.head0", 32'({o_overflow, o_data}), 32'h0001);
    cycle("basic_d0", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("basic.head1", 32'({o_overflow, o_data}), 32'h17FF);
    cycle("basic_d1", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("basic.head2", 32'({o_overflow, o_data}), 32'h0800);
    cycle("basic_d2", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("basic.empty", 32'(o_valid), 32'd0);

    // Full and drop.
    idle_flush();
    for (int i = 0; i < 10; i++)
      cycle("fill", 1'b1, 12'(12'h010 + i), 1'b0, 1'b0, 1'b0);
    check("full.flag", 32'(o_full), 32'd1);
    check("full.count", 32'(o_count), 32'd8);
    check("full.drop", 32'(o_drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("drain.head", 32'(o_data), 32'(12'h010 + i));
      cycle("drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    end

    // Simultaneous push and pop while full.
    idle_flush();
    for (int i = 0; i < 8; i++)
      cycle("fill2", 1'b1, 12'(12'h020 + i), 1'b0, 1'b0, 1'b0);
    cycle("full_pp", 1'b1, 12'h0AA, 1'b0, 1'b1, 1'b0);
    check("full_pp.count", 32'(o_count), 32'd8);
    check("full_pp.drop", 32'(o_drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("full_pp.head", 32'(o_data), (i == 7) ? 32'h0AA : 32'(12'h021 + i));
      cycle("drain2", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    end

    // Streaming through the wrap point with the consumer always ready.
    for (int i = 0; i < 20; i++) begin
      logic [DATA_W-1:0] d;
      d = 12'($urandom);
      cycle("stream", 1'b1, d, 1'b0, 1'b1, 1'b0);
      check("stream.head", 32'(o_data), 32'(d));
      check("stream.count_le1", 32'(o_count <= 1), 32'd1);
    end
    cycle("stream_end", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Drop counter saturation.
    idle_flush();
    for (int i = 0; i < 8; i++)
      cycle("fill3", 1'b1, 12'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++)
      cycle("sat", 1'b1, 12'($urandom), 1'($urandom), 1'b0, 1'b0);
    check("sat.drop", 32'(o_drop_cnt), 32'd255);
    check("sat.ovf", 32'(o_ovf_cnt), 32'd8);

    // Flush overrides a simultaneous push and pop.
    idle_flush();
    for (int i = 0; i < 4; i++)
      cycle("fill4", 1'b1, 12'(12'h300 + i), 1'b1, 1'b0, 1'b0);
    cycle("flush_pri", 1'b1, 12'h5A5, 1'b1, 1'b1, 1'b1);
    check("flush.count", 32'(o_count), 32'd0);
    check("flush.valid", 32'(o_valid), 32'd0);
    check("flush.sticky", 32'(o_ovf_sticky), 32'd0);
    check("flush.ovf_cnt", 32'(o_ovf_cnt), 32'd0);
    check("flush.drop_cnt", 32'(o_drop_cnt), 32'd0);

    // Random traffic, biased towards filling so drops occur.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), 12'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 12-bit ALU: captures every valid ALU result (o_valid/o_data/o_overflow) into a small first-word-fall-through FIFO.
- Presents results to the consumer on a valid/ready handshake, so ALU results issued back-to-back are not lost while the consumer stalls.
- Keeps status:
  - occupancy;
  - sticky overflow flag;
  - saturating counter of overflowed results accepted;
  - saturating counter of results dropped because the buffer was full.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- DATA_W, 12, result width; matches ALU o_data.
- CNT_W, 8, width of the overflow and drop counters.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  ALU result valid; connects to ALU o_valid.
- i_data  input  DATA_W  ALU result; connects to ALU o_data.
- i_overflow  input  1  ALU overflow tag; connects to ALU o_overflow.
- i_flush  input  1  synchronous clear of FIFO contents and status.
- o_valid  output  1  head entry available (FIFO not empty).
- i_ready  input  1  consumer accepts the head entry this cycle.
- o_data  output  DATA_W  head entry data.
- o_overflow  output  1  head entry overflow tag.
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_full  output  1  occupancy == DEPTH.
- o_ovf_sticky  output  1  set when any overflowed result is accepted; cleared only by reset or flush.
- o_ovf_cnt  output  CNT_W  accepted results with the overflow tag; saturates at all-ones.
- o_drop_cnt  output  CNT_W  results discarded because the FIFO was full; saturates at all-ones.

Behaviour:
- Reset (i_rst_n low, asynchronous): clear pointers, o_count, o_ovf_sticky, o_ovf_cnt and o_drop_cnt to 0. Outputs then read o_valid=0, o_full=0, o_data=0, o_overflow=0. Storage array is not reset; o_data is forced to 0 while empty.
- Reset asserted mid-operation discards all entries immediately. After deassertion the block behaves as freshly reset.
- Storage: DEPTH x (DATA_W+1) entries, each {overflow, data}. Write pointer and read pointer wrap modulo DEPTH.
- Push: occurs when i_valid=1 and the entry is accepted. Accepted when !o_full, or when o_full and a pop happens in the same cycle.
- Pop: occurs when o_valid=1 and i_ready=1.
- First-word-fall-through: o_data/o_overflow are combinational reads of the head entry.
  - Latency from push edge to o_valid=1 is one cycle.
  - Pushing into an empty FIFO while i_ready=1 pops that entry on the next edge, not the same one.
- Occupancy updates:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Full with no pop and i_valid=1: result dropped, o_drop_cnt increments (saturating), contents unchanged.
- Empty and i_ready=1 with no push: no pop; nothing changes.
- Overflow accounting: an accepted push with i_overflow=1 sets o_ovf_sticky and increments o_ovf_cnt (saturating). A dropped overflowed result counts only in o_drop_cnt.
- i_flush=1 at an edge clears pointers, count, sticky flag and both counters. It overrides any push or pop in that cycle; the incoming result is neither stored nor counted.
- Counters at all-ones hold the value; they never wrap.
- No arithmetic on data; values pass through bit-exact.

Decomposition:
- Shared package holds:
  - constant ALU_DATA_W=12;
  - a packed typedef for the result entry {ovf, data[11:0]};
  - a localparam helper for pointer width ($clog2(DEPTH)).
- One natural sub-module: sat_counter (CNT_W wide, increment enable, synchronous clear, asynchronous active-low reset). It is instantiated twice, for the overflow count and the drop count.

Test Plan:
- Reset mid-stream:
  - Push 3 results, assert i_rst_n low between edges.
  - Required: o_valid=0, o_count=0 and all counters 0 immediately, before the next clock edge.
- Basic order with i_ready=0:
  - Push 0x001, 0x7FF (ovf=1), 0x800 on three consecutive cycles.
  - Required: o_count=3, o_ovf_sticky=1, o_ovf_cnt=1.
  - Then i_ready=1: outputs 0x001/0, 0x7FF/1, 0x800/0 in order, then o_valid=0.
- Full and drop:
  - DEPTH=8, i_ready=0, push 10 results 0x010..0x019.
  - Required: o_full=1, o_count=8, o_drop_cnt=2.
  - Drain yields 0x010..0x017.
- Simultaneous push/pop at full:
  - Full FIFO, i_ready=1, push 0x0AA.
  - Required: o_count stays 8, o_drop_cnt unchanged, 0x0AA appears after the other 7 entries.
- Wrap-around and saturation:
  - Stream 20 results with i_ready=1 every cycle. Required: each result exits in order one cycle after push, o_count never exceeds 1.
  - Force 260 drops with CNT_W=8. Required: o_drop_cnt=255.
- Flush priority:
  - FIFO holds 4 entries; assert i_flush with i_valid=1 and i_ready=1.
  - Required: next cycle o_count=0, o_valid=0, o_ovf_sticky=0, counters 0.
